// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard, a power-up clearing sweep,
// and same-cycle write bypass on both read ports.
module reg_file_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             busy1,
  output logic             busy2,
  output logic             ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             in_run;

  assign in_run = (state_q == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(DEPTH - 1)) state_d = RUN;
    end
  end

  // NOTE: the array and busy bits have no reset term; the INIT sweep clears them one entry per cycle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (!in_run) begin
        regs[idx_q] <= '0;
        busy[idx_q] <= 1'b0;
      end else begin
        if (wr_en) begin
          regs[wr_addr] <= wr_data;
          busy[wr_addr] <= 1'b0;
        end
        // Ordered after the write so a same-address reserve leaves the register busy.
        if (rsv_en) busy[rsv_addr] <= 1'b1;
      end
    end
  end

  logic hit1, hit2;
  assign hit1 = in_run && wr_en && (wr_addr == rd_addr1);
  assign hit2 = in_run && wr_en && (wr_addr == rd_addr2);

  assign rd_data1 = hit1 ? wr_data : regs[rd_addr1];
  assign rd_data2 = hit2 ? wr_data : regs[rd_addr2];

  // During the sweep every register is reported unavailable.
  assign busy1 = in_run ? (busy[rd_addr1] && !hit1) : 1'b1;
  assign busy2 = in_run ? (busy[rd_addr2] && !hit2) : 1'b1;

  assign ready = in_run;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (WIDTH=16, DEPTH=8).
module tb_reg_file_sb;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             wr_en, rsv_en;
  logic [AW-1:0]    wr_addr, rsv_addr, rd_addr1, rd_addr2;
  logic [WIDTH-1:0] wr_data, rd_data1, rd_data2;
  logic             busy1, busy2, ready;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0; wr_data = '0;

    // Power-up: one reset cycle, then an 8-cycle sweep.
    tick();
    Reset = 1'b0; #1;
    check("init_busy1", busy1, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("init_ready_%0d", i), ready, 0);
      tick();
    end
    check("ready_after_sweep", ready, 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(DEPTH - 1 - a); #1;
      check($sformatf("zero_d1_%0d", a), rd_data1, 0);
      check($sformatf("zero_d2_%0d", a), rd_data2, 0);
      check($sformatf("zero_b1_%0d", a), busy1, 0);
      check($sformatf("zero_b2_%0d", a), busy2, 0);
    end

    // Write bypass on port 1.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr1 = 3'd3; rd_addr2 = 3'd4; #1;
    check("bypass_d1", rd_data1, 16'hBEEF);
    check("bypass_other_port", rd_data2, 0);
    tick();
    wr_en = 1'b0; #1;
    check("stored_d1", rd_data1, 16'hBEEF);

    // Reserve shows next cycle; a write clears busy with same-cycle bypass.
    rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr2 = 3'd5; rd_addr1 = 3'd5; #1;
    check("rsv_same_cycle_b2", busy2, 0);
    tick();
    rsv_en = 1'b0; #1;
    check("rsv_next_b2", busy2, 1);
    check("rsv_next_b1_same_addr", busy1, 1);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; #1;
    check("wr_clears_b2_bypass", busy2, 0);
    check("wr_bypass_d2", rd_data2, 16'h1234);
    check("wr_bypass_d1_same_addr", rd_data1, 16'h1234);
    tick();
    wr_en = 1'b0; #1;
    check("wr_cleared_b2", busy2, 0);
    check("wr_stored_d2", rd_data2, 16'h1234);

    // Same-address write and reserve: data lands, reserve wins.
    wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 3'd2; rsv_addr = 3'd2; wr_data = 16'h00AA; rd_addr1 = 3'd2; #1;
    check("same_addr_bypass_d1", rd_data1, 16'h00AA);
    check("same_addr_bypass_b1", busy1, 0);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; #1;
    check("same_addr_d1", rd_data1, 16'h00AA);
    check("same_addr_b1", busy1, 1);

    // Different addresses: both take effect.
    wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 3'd0; rsv_addr = 3'd6; wr_data = 16'h0F0F; #1;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0; rd_addr1 = 3'd0; rd_addr2 = 3'd6; #1;
    check("diff_d1", rd_data1, 16'h0F0F);
    check("diff_b1", busy1, 0);
    check("diff_b2", busy2, 1);

    // Reset mid-RUN wipes reg 7; strobes during INIT are ignored.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h5555; tick();
    wr_en = 1'b0; rd_addr1 = 3'd7; #1;
    check("pre_reset_d1", rd_data1, 16'h5555);
    Reset = 1'b1; tick();
    Reset = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd7; #1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("rst_ready_%0d", i), ready, 0);
      check($sformatf("rst_busy1_%0d", i), busy1, 1);
      check($sformatf("rst_nobypass_%0d", i), 32'(rd_data1 !== 16'hFFFF), 1);
      tick();
    end
    wr_en = 1'b0; rsv_en = 1'b0; rd_addr2 = 3'd2; #1;
    check("rst_ready_after", ready, 1);
    check("rst_d1_reg7", rd_data1, 0);
    check("rst_b1_reg7", busy1, 0);
    check("rst_b2_reg2", busy2, 0);
    rd_addr2 = 3'd5; #1;
    check("rst_d2_reg5", rd_data2, 0);

    // Reset held two cycles, then asserted again mid-sweep at idx 4.
    Reset = 1'b1; tick(); tick();
    check("hold_ready", ready, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_sweep_ready", ready, 0);
    Reset = 1'b1; tick();
    Reset = 1'b0; #1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("restart_ready_%0d", i), ready, 0);
      tick();
    end
    check("restart_ready_after", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per register.
REQ-002 SHALL have parameter DEPTH, default 8, register count; power of 2, >= 2.
REQ-003 SHALL have derived parameter AW = $clog2(DEPTH), address width.
REQ-004 Clk  in  1  clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  write strobe.
REQ-007 wr_addr  in  AW  write destination register.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 rsv_en  in  1  reserve strobe; marks a register busy (pending writer).
REQ-010 rsv_addr  in  AW  register to reserve.
REQ-011 rd_addr1, rd_addr2  in  AW each  read-port addresses.
REQ-012 rd_data1, rd_data2  out  WIDTH each  read-port data.
REQ-013 busy1, busy2  out  1 each  scoreboard busy flag for rd_addr1/rd_addr2.
REQ-014 ready  out  1  high when the init sweep is done and the file accepts writes/reserves.

Function
REQ-015 SHALL implement a 2-state FSM: INIT and RUN.
REQ-016 INIT: internal index idx counts 0..DEPTH-1, one per cycle; each cycle clears reg[idx] to 0 and busy[idx] to 0.
REQ-017 INIT -> RUN on the edge where idx == DEPTH-1 is cleared; INIT lasts exactly DEPTH cycles.
REQ-018 RUN: SHALL stay in RUN until Reset.
REQ-019 ready SHALL be 1 only in RUN (registered state decode, no combinational input path).
REQ-020 In INIT, wr_en and rsv_en SHALL be ignored: no register or busy bit changes beyond the sweep.
REQ-021 RUN write: wr_en=1 -> reg[wr_addr] <= wr_data at the edge; busy[wr_addr] <= 0.
REQ-022 RUN reserve: rsv_en=1 -> busy[rsv_addr] <= 1 at the edge.
REQ-023 Same-cycle wr_en and rsv_en to the same address: data written AND busy ends 1 (reserve wins).
REQ-024 Same-cycle wr_en and rsv_en to different addresses: both take effect independently.
REQ-025 Reads are combinational: rd_dataN = reg[rd_addrN], zero-latency.
REQ-026 Write bypass: in RUN, if wr_en=1 and wr_addr == rd_addrN, rd_dataN SHALL equal wr_data in the same cycle.
REQ-027 Busy bypass: busyN = busy[rd_addrN] AND NOT (RUN AND wr_en AND wr_addr == rd_addrN).
REQ-028 Reserve has no same-cycle bypass; a new reservation shows on busyN the cycle after rsv_en.
REQ-029 In INIT, rd_dataN SHALL return current array contents (no bypass) and busyN SHALL be 1 (treat all registers unavailable).
REQ-030 Both read ports SHALL be fully independent; rd_addr1 == rd_addr2 returns identical data/busy.
REQ-031 Writing a register that is not busy is legal and behaves per REQ-021.
REQ-032 No address range checks; DEPTH power of 2 makes every AW-bit address valid.

Reset
REQ-033 Reset=1 at a rising edge SHALL force state INIT, idx 0, ready 0 next cycle, regardless of current state or pending strobes.
REQ-034 Reset asserted mid-INIT SHALL restart the sweep at idx 0.
REQ-035 While Reset is held, state stays INIT with idx 0; sweep starts on the first edge with Reset=0.
REQ-036 Register contents not yet swept after Reset are undefined for verification; busy outputs read 1 per REQ-029.
REQ-037 After INIT completes, every reg SHALL read 0 and every busy bit SHALL be 0.

Verification
REQ-038 Reset 1 cycle, release, DEPTH=8 -> ready 0 for 8 cycles, 1 on 9th; all regs read 0, busy1/busy2 = 0.
REQ-039 RUN: wr_en, wr_addr=3, wr_data=16'hBEEF, rd_addr1=3 -> rd_data1=BEEF same cycle (bypass); next cycle, wr_en=0 -> still BEEF.
REQ-040 RUN: rsv_en addr 5 -> busy2 (rd_addr2=5) 0 that cycle, 1 next; then wr_en addr 5 data 16'h1234 -> busy2 0 same cycle, rd_data2=1234.
REQ-041 RUN: rsv_en and wr_en both addr 2 data 16'h00AA -> next cycle reg2=00AA, busy[2]=1.
REQ-042 Write 16'h5555 to reg 7, Reset mid-RUN, release -> ready 0 for 8 cycles; wr_en during INIT ignored; reg 7 reads 0 in RUN.
REQ-043 Reset asserted at INIT idx 4 -> sweep restarts; ready rises exactly 8 cycles after Reset deasserts.
